// File: rtl/fpga_cfg_seq.sv
// fpga_cfg_seq: nCONFIG pulse, CONF_DONE/INIT_DONE supervision with retries, then Z80 warm-reset release.
// Define CFG_RUN_MONITOR_EN to make RUN fall back to ERR when nSTATUS or CONF_DONE drop.
module fpga_cfg_seq #(
  parameter int unsigned      NCFG_LOW_CYC  = 48,
  parameter int unsigned      TMO_W         = 24,
  parameter logic [TMO_W-1:0] TMO_CYC       = TMO_W'(12_000_000),
  parameter int unsigned      MAX_RETRY     = 3,
  parameter int unsigned      WARM_HOLD_CYC = 256
) (
  input  logic       clkin,
  input  logic       coldres_n,
  input  logic       status_n,
  input  logic       conf_done,
  input  logic       init_done,
  input  logic       reconf_req,
  output logic       config_n,
  output wire        warmres_n,
  output logic       cfg_ok,
  output logic       cfg_fail,
  output logic [2:0] retry_cnt
);
  typedef enum logic [2:0] {NCFG_LOW, WAIT_STAT, CONFIG, WAIT_INIT, WARM, RUN, ERR, FAIL} state_t;
  localparam logic [TMO_W-1:0] NCFG_LOAD = TMO_W'(NCFG_LOW_CYC - 1);
  localparam logic [TMO_W-1:0] WARM_LOAD = TMO_W'(WARM_HOLD_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_CYC - TMO_W'(1);
  state_t           state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic [1:0]       stat_q, done_q, init_q;
  logic             config_q, ok_q, fail_q;
  logic             stat_s, done_s, init_s, tmo;
  assign stat_s    = stat_q[1];
  assign done_s    = done_q[1];
  assign init_s    = init_q[1];
  assign tmo       = cnt_q == '0;
  assign config_n  = config_q;
  assign cfg_ok    = ok_q;
  assign cfg_fail  = fail_q;
  assign retry_cnt = retry_q;
  assign warmres_n = ok_q ? 1'bz : 1'b0;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NCFG_LOW:  state_d = tmo ? WAIT_STAT : NCFG_LOW;
      WAIT_STAT: state_d = stat_s ? CONFIG : tmo ? ERR : WAIT_STAT;
      CONFIG:    state_d = !stat_s ? ERR : done_s ? WAIT_INIT : tmo ? ERR : CONFIG;
      WAIT_INIT: state_d = (!stat_s || !done_s) ? ERR : init_s ? WARM : tmo ? ERR : WAIT_INIT;
      WARM:      state_d = tmo ? RUN : WARM;
`ifdef CFG_RUN_MONITOR_EN
      RUN:       state_d = (!stat_s || !done_s) ? ERR : reconf_req ? NCFG_LOW : RUN;
`else
      RUN:       state_d = reconf_req ? NCFG_LOW : RUN;
`endif
      ERR:       state_d = (retry_q >= 3'(MAX_RETRY)) ? FAIL : NCFG_LOW;
      FAIL:      state_d = reconf_req ? NCFG_LOW : FAIL;
    endcase
    // ERR never loops on itself, so landing in it always means a fresh failed attempt
    retry_d = (state_d == ERR) ? ((retry_q == 3'd7) ? retry_q : retry_q + 3'd1) :
              (state_d == NCFG_LOW && (state_q == RUN || state_q == FAIL)) ? 3'd0 : retry_q;
    cnt_d = (state_d != state_q) ? ((state_d == NCFG_LOW) ? NCFG_LOAD : (state_d == WARM) ? WARM_LOAD : TMO_LOAD) :
            tmo ? cnt_q : cnt_q - TMO_W'(1);
  end
  always_ff @(posedge clkin or negedge coldres_n) begin
    if (!coldres_n) begin
      state_q  <= NCFG_LOW;
      cnt_q    <= NCFG_LOAD;
      retry_q  <= '0;
      stat_q   <= '0;
      done_q   <= '0;
      init_q   <= '0;
      config_q <= 1'b0;
      ok_q     <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      stat_q   <= {stat_q[0], status_n};
      done_q   <= {done_q[0], conf_done};
      init_q   <= {init_q[0], init_done};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      config_q <= !(state_d == NCFG_LOW || state_d == FAIL);
      ok_q     <= state_d == RUN;
      fail_q   <= state_d == FAIL;
    end
  end
endmodule

// File: tb/tb_fpga_cfg_seq.sv
// tb_fpga_cfg_seq: directed vector table plus hand-built corner sequences for fpga_cfg_seq.
module tb_fpga_cfg_seq;
  logic       clkin = 1'b0;
  logic       coldres_n = 1'b1;
  logic       status_n, conf_done, init_done, reconf_req;
  logic       config_n, cfg_ok, cfg_fail;
  logic [2:0] retry_cnt;
  wire        warmres_n;
  logic [6:0] outs;
  int         n_cmp = 0;
  int         n_bad = 0;
  typedef struct {
    logic [3:0] in;
    int         cyc;
    logic [6:0] exp;
  } vec_t;
  vec_t tv [33];
  pullup (warmres_n);
  always #5 clkin = ~clkin;
  assign outs = {config_n, warmres_n, cfg_ok, cfg_fail, retry_cnt};
  fpga_cfg_seq #(
    .NCFG_LOW_CYC(4), .TMO_W(24), .TMO_CYC(24'd100), .MAX_RETRY(2), .WARM_HOLD_CYC(8)
  ) dut (
    .clkin(clkin), .coldres_n(coldres_n), .status_n(status_n), .conf_done(conf_done),
    .init_done(init_done), .reconf_req(reconf_req), .config_n(config_n), .warmres_n(warmres_n),
    .cfg_ok(cfg_ok), .cfg_fail(cfg_fail), .retry_cnt(retry_cnt)
  );
  task automatic chk(input string nm, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: {cfg_n,warm,ok,fail,retry} got %b expected %b", nm, got, exp);
    end
  endtask
  task automatic drive(input logic [3:0] v);
    {status_n, conf_done, init_done, reconf_req} = v;
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clkin);
  endtask
  task automatic do_reset;
    step(1);
    drive(4'b0000);
    coldres_n = 1'b0;
    step(2);
    coldres_n = 1'b1;
  endtask
  task automatic boot_run;
    do_reset;
    step(4);
    drive(4'b1000);
    step(3);
    drive(4'b1100);
    step(3);
    drive(4'b1110);
    step(11);
    chk("boot_run", outs, 7'b1110000);
  endtask
  initial begin
    // {status_n, conf_done, init_done, reconf_req}, cycles, {config_n, warmres_n, cfg_ok, cfg_fail, retry_cnt}
    tv[0]  = '{4'b0000, 3,  7'b0000000};
    tv[1]  = '{4'b0000, 1,  7'b1000000};
    tv[2]  = '{4'b1000, 2,  7'b1000000};
    tv[3]  = '{4'b1100, 6,  7'b1000000};
    tv[4]  = '{4'b1110, 10, 7'b1000000};
    tv[5]  = '{4'b1110, 1,  7'b1110000};
    tv[6]  = '{4'b1110, 20, 7'b1110000};
    tv[7]  = '{4'b1111, 1,  7'b0000000};
    tv[8]  = '{4'b0000, 3,  7'b0000000};
    tv[9]  = '{4'b0000, 1,  7'b1000000};
    tv[10] = '{4'b1000, 3,  7'b1000000};
    tv[11] = '{4'b0000, 4,  7'b0000001};
    tv[12] = '{4'b0000, 3,  7'b0000001};
    tv[13] = '{4'b0000, 1,  7'b1000001};
    tv[14] = '{4'b1000, 3,  7'b1000001};
    tv[15] = '{4'b1100, 3,  7'b1000001};
    tv[16] = '{4'b1110, 10, 7'b1000001};
    tv[17] = '{4'b1110, 1,  7'b1110001};
    tv[18] = '{4'b0001, 1,  7'b0000000};
    tv[19] = '{4'b0000, 4,  7'b1000000};
    tv[20] = '{4'b0000, 99, 7'b1000000};
    tv[21] = '{4'b0000, 2,  7'b0000001};
    tv[22] = '{4'b0000, 3,  7'b0000001};
    tv[23] = '{4'b0000, 1,  7'b1000001};
    tv[24] = '{4'b0000, 99, 7'b1000001};
    tv[25] = '{4'b0000, 2,  7'b0001010};
    tv[26] = '{4'b0000, 50, 7'b0001010};
    tv[27] = '{4'b0001, 1,  7'b0000000};
    tv[28] = '{4'b0000, 3,  7'b0000000};
    tv[29] = '{4'b0000, 1,  7'b1000000};
    tv[30] = '{4'b1000, 3,  7'b1000000};
    tv[31] = '{4'b1001, 1,  7'b1000000};
    tv[32] = '{4'b1000, 3,  7'b1000000};
    drive(4'b0000);
    #1 coldres_n = 1'b0;
    #1 chk("reset_state", outs, 7'b0000000);
    step(2);
    coldres_n = 1'b1;
    for (int i = 0; i < 33; i++) begin
      drive(tv[i].in);
      step(tv[i].cyc);
      chk($sformatf("vec%0d", i), outs, tv[i].exp);
    end
    // nSTATUS low and CONF_DONE high reach CONFIG in the same synced cycle
    do_reset;
    step(4);
    drive(4'b1000);
    step(3);
    drive(4'b0100);
    step(4);
    chk("simul_err_beats_done", outs, 7'b0000001);
    // cold reset in the middle of WARM, checked before the next clock edge
    do_reset;
    step(4);
    drive(4'b1000);
    step(3);
    drive(4'b1100);
    step(3);
    drive(4'b1110);
    step(6);
    chk("warm_hold", outs, 7'b1000000);
    #2 coldres_n = 1'b0;
    #1 chk("async_rst_warm", outs, 7'b0000000);
    boot_run;
    #2 coldres_n = 1'b0;
    #1 chk("async_rst_run", outs, 7'b0000000);
    boot_run;
    drive(4'b1010);
    step(4);
`ifdef CFG_RUN_MONITOR_EN
    chk("run_monitor", outs, 7'b0000001);
`else
    chk("run_monitor", outs, 7'b1110000);
    step(20);
    chk("run_monitor_hold", outs, 7'b1110000);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fpga_cfg_seq.md
Name: fpga_cfg_seq

Overview:
Configuration and reset sequencer for the ACEX1K FPGA on the NeoGS board. It replaces the direct coldres_n-to-config_n tie with a state machine. The machine pulses config_n, supervises status_n, conf_done and init_done with timeouts and bounded retries, then releases the Z80 domain via warmres_n. It sits between the cold-reset source and the FPGA config pins, and is clocked from clkin (the buffered Z80 clock output of the clock switch).

Parameters:
NCFG_LOW_CYC, 48, clkin cycles config_n held low per attempt (min 1).
TMO_W, 24, width of timeout counter.
TMO_CYC, 24'd12_000_000, per-phase timeout in clkin cycles (min 2).
MAX_RETRY, 3, failed attempts allowed before FAIL (1..7).
WARM_HOLD_CYC, 256, clkin cycles warmres_n held low after init_done (min 1).

Ports:
clkin  in  1  clock (buffered Z80 clock)
coldres_n  in  1  asynchronous active-low reset
status_n  in  1  FPGA nSTATUS, asynchronous
conf_done  in  1  FPGA CONF_DONE, asynchronous
init_done  in  1  FPGA INIT_DONE, asynchronous
reconf_req  in  1  synchronous single-cycle request to reconfigure
config_n  out  1  FPGA nCONFIG, registered
warmres_n  out  1  Z80 warm reset: 1'b0 when asserted, 1'bZ when released (open-drain)
cfg_ok  out  1  high in RUN
cfg_fail  out  1  high in FAIL
retry_cnt  out  3  failed attempts so far

Behaviour:
- Reset (coldres_n=0, async):
  - state=NCFG_LOW, config_n=0, warmres_n=0, cfg_ok=0, cfg_fail=0, retry_cnt=0.
  - Counters load their entry values; synchroniser flops = 0.
- Synchronisers: status_n, conf_done and init_done each pass through 2 flops. All decisions use synced values, giving 2-cycle input latency.
- Phase counter: loaded on every state entry, decrements by 1 per cycle, saturates at 0. A timeout fires when the counter equals 0 in a waiting state.
- States:
  - NCFG_LOW: config_n=0, warmres_n=0. After exactly NCFG_LOW_CYC cycles in this state -> WAIT_STAT.
  - WAIT_STAT: config_n=1. status_n_s=1 -> CONFIG. Timeout (TMO_CYC cycles) -> ERR.
  - CONFIG: status_n_s=0 -> ERR. Otherwise conf_done_s=1 -> WAIT_INIT. Timeout -> ERR.
    - Priority: an error beats success, so a simultaneous status_n low and conf_done high goes to ERR.
  - WAIT_INIT: status_n_s=0 or conf_done_s=0 -> ERR. init_done_s=1 -> WARM. Timeout -> ERR.
  - WARM: warmres_n=0 for exactly WARM_HOLD_CYC cycles, then RUN.
  - RUN: warmres_n=Z, cfg_ok=1. reconf_req=1 -> retry_cnt=0, NCFG_LOW.
  - ERR (1 cycle): retry_cnt+1. If the new value >= MAX_RETRY -> FAIL, else -> NCFG_LOW.
  - FAIL: config_n=0, warmres_n=0, cfg_fail=1. Only reconf_req (which clears retry_cnt, -> NCFG_LOW) or coldres_n exits.
- warmres_n is 0 in every state except RUN.
- cfg_ok and cfg_fail are registered and mutually exclusive.
- reconf_req is ignored in every state except RUN and FAIL.
- retry_cnt saturates at 7. A successful reach of RUN does not clear it; only reset or an accepted reconf_req does.
- A mid-operation reset returns the block to NCFG_LOW immediately (asynchronously) from any state.

Optional Feature:
CFG_RUN_MONITOR_EN
- Defined: RUN also watches status_n_s=0 or conf_done_s=0. Either condition -> ERR, which reasserts warmres_n and either retries or goes to FAIL per retry_cnt. reconf_req in the same cycle is ignored; the error path wins.
- Undefined: RUN ignores status_n, conf_done and init_done; only reconf_req and reset leave RUN.

Test Plan:
(Bench params: NCFG_LOW_CYC=4, TMO_CYC=100, MAX_RETRY=2, WARM_HOLD_CYC=8.)
1. Normal boot:
   - Stimulus: release coldres_n; raise status_n at cycle 6, conf_done at 30, init_done at 40.
   - Required: config_n low exactly 4 cycles; warmres_n low through WARM, then Z exactly 8 cycles after WARM entry; cfg_ok=1, retry_cnt=0.
2. CONFIG error:
   - Stimulus: status_n drops during CONFIG on the first attempt; the second attempt succeeds.
   - Required: second config_n low pulse of 4 cycles; retry_cnt=1; ends in RUN.
3. Timeout to FAIL:
   - Stimulus: hold status_n=0 forever.
   - Required: two attempts, each WAIT_STAT lasting 100 cycles; cfg_fail=1, retry_cnt=2, config_n=0, warmres_n=0 held indefinitely.
4. Recovery from FAIL and RUN:
   - Stimulus: reconf_req pulse in FAIL, then again in RUN.
   - Required: each pulse clears retry_cnt to 0, drives config_n low next cycle and deasserts cfg_ok/cfg_fail. A pulse during CONFIG has no effect.
5. Simultaneous and async events:
   - Stimulus: status_n low and conf_done high in the same synced cycle. Then assert coldres_n low mid-WARM.
   - Required: the first goes to ERR, not WAIT_INIT. The reset sets config_n=0, warmres_n=0, cfg_ok=0 asynchronously, without waiting for a clkin edge.
6. Monitor:
   - Stimulus: drop conf_done in RUN.
   - Required with CFG_RUN_MONITOR_EN: ERR then NCFG_LOW, warmres_n=0, retry_cnt+1.
   - Required without it: remains in RUN, cfg_ok=1.
